// File: rtl/tinyalu_stim_gen_if.sv
// TinyALU bus between the stimulus generator (master) and the ALU (slave).
// Handshake: the master raises start with stable A/B/op and holds it until done=1; result is valid only in a cycle with done=1.
interface tinyalu_stim_gen_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0]   A;
  logic [DATA_W-1:0]   B;
  logic [2:0]          op;
  logic                start;
  logic                done;
  logic [2*DATA_W-1:0] result;

  modport master (output A, B, op, start, input done, result);
  modport slave  (input A, B, op, start, output done, result);
endinterface

// File: rtl/tinyalu_stim_gen.sv
// Constrained-random TinyALU bus master: LFSR-driven operands and opcodes, start/done handshake,
// built-in result predictor with transaction, mismatch and timeout accounting.
module tinyalu_stim_gen #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_TXN   = 1000,
  parameter logic [31:0] SEED      = 32'hACE1,
  parameter bit          CORNER_EN = 1'b1,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  tinyalu_stim_gen_if.master  alu,
  output logic                busy,
  output logic                finished,
  output logic [31:0]         txn_count,
  output logic [15:0]         err_count,
  output logic                timeout_err,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN_A = 3'd1,
    S_GEN_B = 3'd2,
    S_DRIVE = 3'd3,
    S_WAIT  = 3'd4,
    S_NEXT  = 3'd5,
    S_FIN   = 3'd6
  } state_e;

  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] NUM_TXN_W = 32'(NUM_TXN);
  localparam int unsigned WC_W      = $clog2(TIMEOUT + 2);
  localparam logic [WC_W-1:0] TIMEOUT_C = WC_W'(TIMEOUT);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  state_e              state, state_nxt;
  logic [31:0]         lfsr, lfsr_nxt;
  logic [1:0]          sel_b;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [2:0]          op_q;
  logic [WC_W-1:0]     wait_cnt;
  logic [2*DATA_W-1:0] expected;
  logic [31:0]         txn_q;
  logic [15:0]         err_q;
  logic                to_q;

  logic lfsr_adv, load_a, load_b, txn_inc, err_inc, to_set, wait_clr, wait_inc;

  function automatic logic [2:0] map_op(input logic [2:0] choice);
    case (choice)
      3'b001, 3'b110: map_op = OP_ADD;
      3'b010:         map_op = OP_AND;
      3'b011, 3'b111: map_op = OP_XOR;
      3'b100:         map_op = OP_MUL;
      default:        map_op = OP_NOP;
    endcase
  endfunction

  // Selector 00/11 pins the operand to a corner value when corners are enabled.
  function automatic logic [DATA_W-1:0] pick_operand(input logic [1:0] sel,
                                                     input logic [DATA_W-1:0] raw);
    if (CORNER_EN && (sel == 2'b00))      pick_operand = '0;
    else if (CORNER_EN && (sel == 2'b11)) pick_operand = '1;
    else                                  pick_operand = raw;
  endfunction

  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  always_comb begin
    expected = '0;
    case (op_q)
      OP_ADD:  expected = {{DATA_W{1'b0}}, a_q} + {{DATA_W{1'b0}}, b_q};
      OP_AND:  expected = {{DATA_W{1'b0}}, a_q & b_q};
      OP_XOR:  expected = {{DATA_W{1'b0}}, a_q ^ b_q};
      OP_MUL:  expected = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
      default: expected = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lfsr_adv  = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    txn_inc   = 1'b0;
    err_inc   = 1'b0;
    to_set    = 1'b0;
    wait_clr  = 1'b0;
    wait_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && (txn_q < NUM_TXN_W)) state_nxt = S_GEN_A;
      end
      S_GEN_A: begin
        lfsr_adv  = 1'b1;
        load_a    = 1'b1;
        state_nxt = S_GEN_B;
      end
      S_GEN_B: begin
        lfsr_adv  = 1'b1;
        load_b    = 1'b1;
        state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        // wait_cnt counts start-high cycles already completed; DRIVE is the first.
        wait_clr  = 1'b1;
        state_nxt = (op_q == OP_NOP) ? S_NEXT : S_WAIT;
      end
      S_WAIT: begin
        if (alu.done) begin
          err_inc   = (alu.result != expected);
          state_nxt = S_NEXT;
        end else if ((wait_cnt + WC_W'(1)) >= TIMEOUT_C) begin
          to_set    = 1'b1;
          err_inc   = 1'b1;
          state_nxt = S_NEXT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_NEXT: begin
        txn_inc = 1'b1;
        if ((txn_q + 32'd1) == NUM_TXN_W) state_nxt = S_FIN;
        else if (enable)                  state_nxt = S_GEN_A;
        else                              state_nxt = S_IDLE;
      end
      S_FIN:   state_nxt = S_FIN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= SEED_EFF;
      sel_b    <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NOP;
      wait_cnt <= '0;
      txn_q    <= '0;
      err_q    <= '0;
      to_q     <= 1'b0;
    end else begin
      if (lfsr_adv) lfsr <= lfsr_nxt;
      if (load_a) begin
        op_q  <= map_op(lfsr[2:0]);
        sel_b <= lfsr[6:5];
        a_q   <= pick_operand(lfsr[4:3], lfsr[7 +: DATA_W]);
      end
      if (load_b) b_q <= pick_operand(sel_b, lfsr[0 +: DATA_W]);
      if (wait_clr)      wait_cnt <= WC_W'(1);
      else if (wait_inc) wait_cnt <= wait_cnt + WC_W'(1);
      if (txn_inc) txn_q <= txn_q + 32'd1;
      if (err_inc && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
      if (to_set) to_q <= 1'b1;
    end
  end

  assign alu.A       = a_q;
  assign alu.B       = b_q;
  assign alu.op      = op_q;
  assign alu.start   = (state == S_DRIVE) || (state == S_WAIT);
  assign busy        = (state != S_IDLE) && (state != S_FIN);
  assign finished    = (state == S_FIN);
  assign txn_count   = txn_q;
  assign err_count   = err_q;
  assign timeout_err = to_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_tinyalu_stim_gen.sv
// Bench for tinyalu_stim_gen: responder ALU models on two instances, LFSR-level transaction model,
// one task per scenario.
module tb_tinyalu_stim_gen;
  localparam int W = 8;
  localparam int N_TXN = 100;
  localparam int TW = 3 + 2 * W;
  localparam int M_OK = 0, M_INV = 1, M_NEVER = 2;

  logic clk, reset, enable, enable5;
  logic busy, finished, timeout_err, busy5, finished5, timeout_err5;
  logic [31:0] txn_count, txn_count5;
  logic [15:0] err_count, err_count5;
  logic [2:0] state_dbg, state_dbg5;

  tinyalu_stim_gen_if #(.DATA_W(W)) bus ();
  tinyalu_stim_gen_if #(.DATA_W(W)) bus5 ();

  tinyalu_stim_gen #(.DATA_W(W), .NUM_TXN(N_TXN), .SEED(32'hACE1), .CORNER_EN(1'b1), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .alu(bus), .busy(busy), .finished(finished),
    .txn_count(txn_count), .err_count(err_count), .timeout_err(timeout_err), .state_dbg(state_dbg));

  // Seed 0x7C makes the first transaction mul with both selectors at 11 (A=B=all-ones).
  tinyalu_stim_gen #(.DATA_W(W), .NUM_TXN(1), .SEED(32'h0000_007C), .CORNER_EN(1'b1), .TIMEOUT(8)) dut5 (
    .clk(clk), .reset(reset), .enable(enable5), .alu(bus5), .busy(busy5), .finished(finished5),
    .txn_count(txn_count5), .err_count(err_count5), .timeout_err(timeout_err5), .state_dbg(state_dbg5));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] obs_q[$], obs5_q[$];
  int width_q[$], width5_q[$];
  int unstable = 0, unstable5 = 0;
  int n_ops = 0;
  int alu_mode = M_OK, alu_delay = 1, alu_delay5 = 3;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [W-1:0] corner(input logic [1:0] sel, input logic [W-1:0] raw);
    if (sel == 2'b00) return '0;
    if (sel == 2'b11) return '1;
    return raw;
  endfunction

  function automatic logic [2*W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ia = a, ib = b;
    case (op)
      3'd1: return 16'(ia + ib);
      3'd2: return 16'(ia & ib);
      3'd3: return 16'(ia ^ ib);
      3'd4: return 16'(ia * ib);
      default: return '0;
    endcase
  endfunction

  task automatic build_model(input logic [31:0] seed, input int n);
    logic [31:0] s, w1, w2;
    logic [2:0] op_map [8];
    op_map = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd3};
    s = (seed == 0) ? 32'd1 : seed;
    exp_q.delete();
    n_ops = 0;
    for (int i = 0; i < n; i++) begin
      w1 = s; s = lfsr_step(s);
      w2 = s; s = lfsr_step(s);
      exp_q.push_back({op_map[w1[2:0]], corner(w1[4:3], w1[14:7]), corner(w1[6:5], w2[7:0])});
      if (op_map[w1[2:0]] != 3'd0) n_ops++;
    end
  endtask

  // ---------------- ALU responders (drive at negedge) ----------------
  int r_cnt = 0, r_cnt5 = 0;
  always @(negedge clk) begin
    if (reset || !bus.start || bus.op == 3'd0 || alu_mode == M_NEVER) begin
      r_cnt = 0; bus.done = 1'b0; bus.result = '0;
    end else begin
      r_cnt++;
      bus.done = (r_cnt == alu_delay + 1);
      bus.result = alu_ref(bus.op, bus.A, bus.B) ^ ((alu_mode == M_INV) ? 16'd1 : 16'd0);
    end
  end

  always @(negedge clk) begin
    if (reset || !bus5.start || bus5.op == 3'd0) begin
      r_cnt5 = 0; bus5.done = 1'b0; bus5.result = '0;
    end else begin
      r_cnt5++;
      bus5.done = (r_cnt5 == alu_delay5 + 1);
      bus5.result = alu_ref(bus5.op, bus5.A, bus5.B);
    end
  end

  // ---------------- monitors ----------------
  logic m_prev = 1'b0, m_prev5 = 1'b0;
  int m_w = 0, m_w5 = 0;
  logic [TW-1:0] m_hold, m_hold5;
  always @(negedge clk) begin
    if (reset) begin
      m_prev = 1'b0; m_w = 0;
    end else begin
      if (bus.start) begin
        if (!m_prev) begin obs_q.push_back({bus.op, bus.A, bus.B}); m_w = 0; end
        else if ({bus.op, bus.A, bus.B} != m_hold) unstable++;
        m_hold = {bus.op, bus.A, bus.B};
        m_w++;
      end else if (m_prev) width_q.push_back(m_w);
      m_prev = bus.start;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      m_prev5 = 1'b0; m_w5 = 0;
    end else begin
      if (bus5.start) begin
        if (!m_prev5) begin obs5_q.push_back({bus5.op, bus5.A, bus5.B}); m_w5 = 0; end
        else if ({bus5.op, bus5.A, bus5.B} != m_hold5) unstable5++;
        m_hold5 = {bus5.op, bus5.A, bus5.B};
        m_w5++;
      end else if (m_prev5) width5_q.push_back(m_w5);
      m_prev5 = bus5.start;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    obs_q.delete(); width_q.delete(); unstable = 0;
    reset = 1'b0;
  endtask

  task automatic wait_finished(input int budget);
    for (int i = 0; i < budget && finished !== 1'b1; i++) @(negedge clk);
    checks++;
    if (finished !== 1'b1) begin errors++; $display("FAIL finish_timeout: finished=%b want 1", finished); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; enable5 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.A !== 8'h00) begin errors++; $display("FAIL rst_A: got %h want 00", bus.A); end
    checks++; if (bus.B !== 8'h00) begin errors++; $display("FAIL rst_B: got %h want 00", bus.B); end
    checks++; if (bus.op !== 3'd0) begin errors++; $display("FAIL rst_op: got %0d want 0", bus.op); end
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b want 0", bus.start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL rst_finished: got %b want 0", finished); end
    checks++; if (txn_count !== 32'd0) begin errors++; $display("FAIL rst_txn: got %0d want 0", txn_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err: got %0d want 0", err_count); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.start !== 1'b0 || obs_q.size() != 0) begin
      errors++; $display("FAIL idle_hold: busy=%b start=%b txns=%0d want 0/0/0", busy, bus.start, obs_q.size());
    end
  endtask

  task automatic test_correct_alu();
    alu_mode = M_OK; alu_delay = 1;
    @(negedge clk);
    enable = 1'b1;
    wait_finished(3000);
    checks++; if (txn_count !== 32'd100) begin errors++; $display("FAIL ok_txn: got %0d want 100", txn_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL ok_err: got %0d want 0", err_count); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ok_timeout: got %b want 0", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ok_busy_fin: got %b want 0", busy); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL ok_stable: got %0d changes want 0", unstable); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ok_seq_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ok_seq[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < width_q.size() && i < exp_q.size(); i++) begin
      logic [TW-1:0] e;
      e = exp_q[i];
      checks++;
      if (width_q[i] != ((e[TW-1:TW-3] == 3'd0) ? 1 : 2)) begin
        errors++; $display("FAIL ok_start_width[%0d]: got %0d want %0d", i, width_q[i], (e[TW-1:TW-3] == 3'd0) ? 1 : 2);
      end
    end
  endtask

  task automatic test_bad_alu();
    alu_mode = M_INV; alu_delay = 1;
    apply_reset();
    wait_finished(3000);
    checks++; if (err_count !== 16'(n_ops)) begin errors++; $display("FAIL bad_err: got %0d want %0d", err_count, n_ops); end
    checks++; if (txn_count !== 32'd100) begin errors++; $display("FAIL bad_txn: got %0d want 100", txn_count); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL bad_timeout: got %b want 0", timeout_err); end
  endtask

  task automatic test_timeout();
    alu_mode = M_NEVER;
    apply_reset();
    wait_finished(5000);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", timeout_err); end
    checks++; if (err_count !== 16'(n_ops)) begin errors++; $display("FAIL to_err: got %0d want %0d", err_count, n_ops); end
    checks++; if (txn_count !== 32'd100) begin errors++; $display("FAIL to_txn: got %0d want 100", txn_count); end
    checks++;
    if (width_q.size() != exp_q.size()) begin errors++; $display("FAIL to_width_len: got %0d want %0d", width_q.size(), exp_q.size()); end
    for (int i = 0; i < width_q.size() && i < exp_q.size(); i++) begin
      logic [TW-1:0] e;
      e = exp_q[i];
      checks++;
      if (width_q[i] != ((e[TW-1:TW-3] == 3'd0) ? 1 : 8)) begin
        errors++; $display("FAIL to_start_width[%0d]: got %0d want %0d", i, width_q[i], (e[TW-1:TW-3] == 3'd0) ? 1 : 8);
      end
    end
  endtask

  task automatic test_mul_delay();
    logic [TW-1:0] want;
    want = {3'd4, 8'hFF, 8'hFF};
    @(negedge clk);
    enable5 = 1'b1;
    for (int i = 0; i < 200 && finished5 !== 1'b1; i++) @(negedge clk);
    checks++; if (finished5 !== 1'b1) begin errors++; $display("FAIL mul_finished: got %b want 1", finished5); end
    checks++;
    if (obs5_q.size() != 1) begin errors++; $display("FAIL mul_count: got %0d want 1", obs5_q.size()); end
    else begin
      checks++; if (obs5_q[0] !== want) begin errors++; $display("FAIL mul_txn: got %h want %h", obs5_q[0], want); end
    end
    checks++;
    if (width5_q.size() != 1 || width5_q[0] != 4) begin
      errors++; $display("FAIL mul_start_width: got %0d want 4", (width5_q.size() > 0) ? width5_q[0] : -1);
    end
    checks++; if (unstable5 !== 0) begin errors++; $display("FAIL mul_stable: got %0d changes want 0", unstable5); end
    checks++; if (err_count5 !== 16'd0) begin errors++; $display("FAIL mul_err: got %0d want 0", err_count5); end
    checks++; if (txn_count5 !== 32'd1) begin errors++; $display("FAIL mul_txn_count: got %0d want 1", txn_count5); end
  endtask

  task automatic test_reset_mid_txn();
    alu_mode = M_NEVER;
    apply_reset();
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL mid_inflight: start=%b want 1", bus.start); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL mid_start: got %b want 0", bus.start); end
    checks++; if (txn_count !== 32'd0) begin errors++; $display("FAIL mid_txn: got %0d want 0", txn_count); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL mid_err: got %0d want 0", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    alu_mode = M_OK;
    obs_q.delete(); width_q.delete();
    reset = 1'b0;
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) @(negedge clk);
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL mid_restart: no transaction, want %h", exp_q[0]); end
    else if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL mid_restart: got %h want %h", obs_q[0], exp_q[0]); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1; enable = 1'b0; enable5 = 1'b0;
    build_model(32'hACE1, N_TXN);
    test_reset();
    test_correct_alu();
    test_bad_alu();
    test_timeout();
    test_mul_delay();
    test_reset_mid_txn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end
endmodule
